data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//   Responder side of the MEM-stage data-memory interface. Accepts one load/store
//   request at a time over a valid/ready handshake and performs it against a
//   byte-addressable, little-endian RAM after a programmable number of wait states.
//   Returns a single-cycle response pulse with read data and an error flag.
//   Sits behind the MEM stage; the pipeline stalls on req_ready/rsp_valid.
// PARAMETERS
//   DEPTH_BYTES  1024  RAM size in bytes; valid byte addresses 0..DEPTH_BYTES-1
//   WAIT_STATES  2     extra cycles between accept and the memory access (0 legal)
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   req_valid  in   1   request present; fields below must be stable while valid
//   req_ready  out  1   responder can accept (high only in IDLE)
//   req_wr     in   1   1 = store, 0 = load
//   req_size   in   2   numberOfByte: 2'd1 = byte, 2'd2 = halfword; 0/3 illegal
//   req_addr   in   16  byte address (ALU result)
//   req_wdata  in   16  store data; byte store uses [7:0]
//   rsp_valid  out  1   one-cycle response pulse; no backpressure
//   rsp_rdata  out  16  load data; 0 for stores and errors
//   rsp_err    out  1   request rejected (illegal size, misaligned, out of range)
// BEHAVIOUR
//   Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//     wait counter=0. RAM contents are NOT reset.
//   FSM: IDLE -> WAIT -> ACCESS -> RESP -> IDLE.
//   - IDLE: req_ready=1. On req_valid&&req_ready at edge E0, latch wr/size/addr/wdata;
//     go to WAIT with cnt=WAIT_STATES (go directly to ACCESS if WAIT_STATES==0).
//   - WAIT: cnt decrements each edge; on the edge where cnt==1, go to ACCESS.
//   - ACCESS: on the next edge, perform the access, register the response, go to RESP.
//   - RESP: rsp_valid=1 for exactly one cycle; next edge -> IDLE (req_ready=1).
//   Latency: rsp_valid is high in the cycle after edge E0+WAIT_STATES+1. Next accept
//     is no earlier than edge E0+WAIT_STATES+3. Throughput: one request per
//     WAIT_STATES+3 cycles.
//   req_ready=0 in WAIT/ACCESS/RESP; req_valid in these states is ignored, not queued.
//   Error check, evaluated on the latched request in ACCESS:
//   - size not in {1,2}
//   - size==2 with addr[0]==1
//   - addr+size-1 >= DEPTH_BYTES (compute in 17 bits; no wrap)
//   On error: no RAM write, rsp_rdata=0, rsp_err=1.
//   Load byte: rsp_rdata = {8'h00, mem[addr]} (zero-extend).
//   Load half: rsp_rdata = {mem[addr+1], mem[addr]}.
//   Store byte: mem[addr] <= wdata[7:0].
//   Store half: mem[addr] <= wdata[7:0]; mem[addr+1] <= wdata[15:8].
//   Store response: rsp_valid=1, rsp_rdata=0, rsp_err=0.
//   rsp_rdata/rsp_err hold their last value outside RESP; consumers qualify with rsp_valid.
//   RAM is written only on the ACCESS edge, so no partial writes are possible.
//   Reset mid-operation: asserting rst_n in WAIT/ACCESS aborts the request. No write
//     occurs unless the ACCESS edge has already passed. All outputs take reset values.
//   A store immediately followed by a load to the same address returns the new data.
// TESTING
//   1. WAIT_STATES=2: store half 16'hBEEF @0x0010, then load half @0x0010
//      -> rdata=16'hBEEF, rsp_valid 3 cycles after each accept, err=0.
//   2. Store byte 8'h5A @0x0011 over the case-1 data; load half @0x0010
//      -> 16'h5AEF. Load byte @0x0011 -> 16'h005A.
//   3. Load half @0x0013 -> err=1, rdata=0. Store with size=0 @0x0020 -> err=1 and
//      mem[0x20] unchanged. Load byte @DEPTH_BYTES -> err=1.
//   4. Store half @DEPTH_BYTES-1 (crosses end) -> err=1, no byte written.
//      Load byte @DEPTH_BYTES-1 -> err=0.
//   5. Hold req_valid high continuously with back-to-back requests
//      -> req_ready low in WAIT/ACCESS/RESP; each request is accepted once, in order.
//   6. Reset: drop rst_n during WAIT of a store 16'h1234 @0x30
//      -> rsp_valid never pulses, req_ready=1 after release, later load @0x30
//      returns the old value. Repeat with WAIT_STATES=0 -> response 1 cycle after accept.

Source files
------------

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - MEM-stage data-memory responder with programmable wait states
module data_memory_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW    = (DEPTH_BYTES < 2) ? 1 : $clog2(DEPTH_BYTES);
  localparam int          CW    = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [16:0] LIMIT = 17'(DEPTH_BYTES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic          wr_q;
  logic [1:0]    size_q;
  logic [15:0]   addr_q;
  logic [15:0]   wdata_q;

  logic [7:0]    mem [DEPTH_BYTES];

  logic          accept;
  logic [16:0]   last_byte;
  logic          bad_size;
  logic          misaligned;
  logic          out_of_range;
  logic          req_err;
  logic [AW-1:0] idx_lo;
  logic [AW-1:0] idx_hi;
  logic [15:0]   rd_data;
  logic          do_write;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  // Error checks on the latched request; the end address is formed in 17 bits so it cannot wrap.
  assign last_byte    = {1'b0, addr_q} + {15'd0, size_q} - 17'd1;
  assign bad_size     = (size_q != 2'd1) && (size_q != 2'd2);
  assign misaligned   = (size_q == 2'd2) && addr_q[0];
  assign out_of_range = (last_byte >= LIMIT);
  assign req_err      = bad_size || misaligned || out_of_range;

  // The upper address bits only matter for the range check above; indexing uses the low bits.
  assign idx_lo = addr_q[AW-1:0];
  assign idx_hi = idx_lo + AW'(1);

  assign do_write = rst_n && (state_q == S_ACCESS) && wr_q && !req_err;

  // Little-endian read of one or two bytes; byte loads are zero-extended.
  always_comb begin
    rd_data = 16'h0000;
    if (size_q == 2'd1) begin
      rd_data = {8'h00, mem[idx_lo]};
    end else begin
      rd_data = {mem[idx_hi], mem[idx_lo]};
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> WAIT (skipped when there are no wait states) -> ACCESS -> RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Capture the request on accept; requests arriving while busy are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
    end else if (accept) begin
      wr_q    <= req_wr;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Register the response on the ACCESS edge; data and error hold until the next access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0000;
      rsp_err   <= 1'b0;
    end else if (state_q == S_ACCESS) begin
      rsp_valid <= 1'b1;
      rsp_err   <= req_err;
      rsp_rdata <= (req_err || wr_q) ? 16'h0000 : rd_data;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

  // RAM write port: only on the ACCESS edge of a legal store, so a store lands whole or not at all.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[idx_lo] <= wdata_q[7:0];
      if (size_q == 2'd2) begin
        mem[idx_hi] <= wdata_q[15:8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - scoreboard bench for data_memory_responder
`timescale 1ns/1ps
module tb_data_memory_responder;

  localparam int DEPTH = 1024;
  localparam int WS    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Instance A: default wait states, scoreboard checked
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  // Instance B: zero wait states
  logic        b_rst_n;
  logic        b_valid;
  logic        b_ready;
  logic        b_wr;
  logic [1:0]  b_size;
  logic [15:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_rsp_valid;
  logic [15:0] b_rdata;
  logic        b_err;

  data_memory_responder #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  data_memory_responder #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk       (clk),
    .rst_n     (b_rst_n),
    .req_valid (b_valid),
    .req_ready (b_ready),
    .req_wr    (b_wr),
    .req_size  (b_size),
    .req_addr  (b_addr),
    .req_wdata (b_wdata),
    .rsp_valid (b_rsp_valid),
    .rsp_rdata (b_rdata),
    .rsp_err   (b_err)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain byte array updated in request order
  logic [7:0] ref_mem [DEPTH];

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t exp_q[$];

  function automatic void model(input bit wr, input int size, input int addr,
                                input logic [15:0] wdata,
                                output logic [15:0] rdata, output logic err);
    err   = 1'b0;
    rdata = 16'h0000;
    if (size != 1 && size != 2)            err = 1'b1;
    else if (size == 2 && (addr % 2) != 0) err = 1'b1;
    else if (addr + size - 1 >= DEPTH)     err = 1'b1;
    if (err) return;
    if (wr) begin
      ref_mem[addr] = wdata[7:0];
      if (size == 2) ref_mem[addr + 1] = wdata[15:8];
    end else if (size == 1) begin
      rdata = {8'h00, ref_mem[addr]};
    end else begin
      rdata = {ref_mem[addr + 1], ref_mem[addr]};
    end
  endfunction

  // Issue one request to A; called and returns at a falling edge
  task automatic a_req(input bit wr, input logic [1:0] size, input logic [15:0] addr,
                       input logic [15:0] wdata, input bit keep, input bit chk_gap,
                       input bit record);
    logic [15:0] rd;
    logic        er;
    int          waited;
    exp_t        e;
    req_wr    = wr;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    waited    = 0;
    while (req_ready !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (chk_gap) check("b2b_gap", 32'(waited), 32'(WS + 2));
    @(posedge clk);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    check("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
    if (record) begin
      model(wr, int'(size), int'(addr), wdata, rd, er);
      e.rdata = rd;
      e.err   = er;
      e.due   = cyc + WS + 1;
      exp_q.push_back(e);
    end
  endtask

  // Monitor for A: pops one expectation per response pulse
  always @(negedge clk) begin : mon
    exp_t me;
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        me = exp_q.pop_front();
        check("rsp_rdata",   {16'd0, rsp_rdata}, {16'd0, me.rdata});
        check("rsp_err",     {31'd0, rsp_err},   {31'd0, me.err});
        check("rsp_latency", 32'(cyc),           32'(me.due));
      end
    end
  end

  // Issue one request to B and check its response timing directly
  task automatic b_req(input bit wr, input logic [1:0] size, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rd, input bit exp_er);
    int waited;
    b_wr    = wr;
    b_size  = size;
    b_addr  = addr;
    b_wdata = wdata;
    b_valid = 1'b1;
    waited  = 0;
    while (b_ready !== 1'b1 && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    if (b_ready !== 1'b1) begin
      check("b_accept_timeout", 32'd0, 32'd1);
      b_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    check("b_rsp_not_yet", {31'd0, b_rsp_valid}, 32'd0);
    @(negedge clk);
    check("b_rsp_valid", {31'd0, b_rsp_valid}, 32'd1);
    check("b_rdata",     {16'd0, b_rdata},     {16'd0, exp_rd});
    check("b_err",       {31'd0, b_err},       {31'd0, exp_er});
    @(negedge clk);
    check("b_rsp_pulse_end", {31'd0, b_rsp_valid}, 32'd0);
    check("b_ready_back",    {31'd0, b_ready},     32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          wr;
    logic [1:0]  sz;
    logic [15:0] ad;
    int          r;

    rst_n = 1'b0;  b_rst_n = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
    b_valid = 1'b0; b_wr = 1'b0; b_size = 2'd0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ready",     {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rdata",     {16'd0, rsp_rdata}, 32'd0);
    check("reset_err",       {31'd0, rsp_err},   32'd0);
    rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {31'd0, req_ready}, 32'd1);

    // Fill the whole RAM so every later load has a known expectation
    for (int a = 0; a < DEPTH; a += 2) a_req(1'b1, 2'd2, 16'(a), 16'($urandom), 1'b0, 1'b0, 1'b1);

    // Directed: store/load, byte overlay, errors, end-of-RAM boundary
    a_req(1'b1, 2'd2, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    a_req(1'b0, 2'd2, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1);
    a_req(1'b1, 2'd1, 16'h0011, 16'h005A, 1'b0, 1'b0, 1'b1);
    a_req(1'b0, 2'd2, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1);
    a_req(1'b0, 2'd1, 16'h0011, 16'h0000, 1'b0, 1'b0, 1'b1);
    a_req(1'b0, 2'd2, 16'h0013, 16'h0000, 1'b0, 1'b0, 1'b1);
    a_req(1'b1, 2'd0, 16'h0020, 16'h7777, 1'b0, 1'b0, 1'b1);
    a_req(1'b0, 2'd1, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b1);
    a_req(1'b0, 2'd1, 16'(DEPTH),     16'h0000, 1'b0, 1'b0, 1'b1);
    a_req(1'b1, 2'd2, 16'(DEPTH - 1), 16'hCAFE, 1'b0, 1'b0, 1'b1);
    a_req(1'b0, 2'd1, 16'(DEPTH - 1), 16'h0000, 1'b0, 1'b0, 1'b1);
    a_req(1'b0, 2'd2, 16'(DEPTH - 2), 16'h0000, 1'b0, 1'b0, 1'b1);
    a_req(1'b1, 2'd3, 16'h0040, 16'h1111, 1'b0, 1'b0, 1'b1);
    a_req(1'b0, 2'd2, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Randomized mix with idle gaps
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      sz = (r < 4) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd0 : 2'd3;
      r  = $urandom_range(0, 9);
      if (r == 0)      ad = 16'($urandom);
      else if (r == 1) ad = 16'(DEPTH - 2 + $urandom_range(0, 3));
      else             ad = 16'($urandom_range(0, DEPTH - 1));
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) ad[0] = 1'b0;
      a_req(wr, sz, ad, 16'($urandom), 1'b0, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Back-to-back with req_valid held high throughout
    for (int i = 0; i < 20; i++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(1, 2));
      ad = 16'($urandom_range(0, 63));
      if (sz == 2'd2) ad[0] = 1'b0;
      a_req(wr, sz, ad, 16'($urandom), (i < 19), (i > 0), 1'b1);
    end

    // Reset during WAIT aborts a store
    a_req(1'b1, 2'd2, 16'h0030, 16'hC3A5, 1'b0, 1'b0, 1'b1);
    a_req(1'b0, 2'd2, 16'h0030, 16'h0000, 1'b0, 1'b0, 1'b1);
    a_req(1'b1, 2'd2, 16'h0030, 16'h1234, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_ready",     {31'd0, req_ready}, 32'd1);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_rdata",     {16'd0, rsp_rdata}, 32'd0);
    check("abort_err",       {31'd0, rsp_err},   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    check("abort_ready_after", {31'd0, req_ready}, 32'd1);
    a_req(1'b0, 2'd2, 16'h0030, 16'h0000, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 64 && exp_q.size() > 0; k++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Zero wait states: one-cycle latency and reset during ACCESS
    b_req(1'b1, 2'd2, 16'h0040, 16'hA55A, 16'h0000, 1'b0);
    b_req(1'b0, 2'd2, 16'h0040, 16'h0000, 16'hA55A, 1'b0);
    b_req(1'b0, 2'd1, 16'h0041, 16'h0000, 16'h00A5, 1'b0);
    b_req(1'b0, 2'd1, 16'(DEPTH), 16'h0000, 16'h0000, 1'b1);
    b_wr = 1'b1; b_size = 2'd2; b_addr = 16'h0040; b_wdata = 16'h1234; b_valid = 1'b1;
    for (int k = 0; k < 16 && b_ready !== 1'b1; k++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    b_rst_n = 1'b0;
    #1;
    check("b_abort_ready",     {31'd0, b_ready},     32'd1);
    check("b_abort_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    @(negedge clk);
    b_rst_n = 1'b1;
    @(negedge clk);
    check("b_abort_no_rsp", {31'd0, b_rsp_valid}, 32'd0);
    b_req(1'b0, 2'd2, 16'h0040, 16'h0000, 16'hA55A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
